// File: rtl/dcf77_display.sv
// Time display for the dcf77 decoder: latches BCD fields on load, shows one of four
// pages on 4 or 6 active-low seven-segment digits, and blinks on error or stale data.
module dcf77_display #(
  parameter int unsigned CLK_HZ   = 24_000_000,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BLINK_HZ = 2,
  parameter int unsigned ROTATE_S = 3,
  parameter int unsigned STALE_S  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [6:0]            second,
  input  logic [6:0]            minute,
  input  logic [5:0]            hour,
  input  logic [5:0]            day,
  input  logic [2:0]            week_day,
  input  logic [4:0]            month,
  input  logic [7:0]            year,
  input  logic                  error,
  input  logic                  auto_mode,
  input  logic [1:0]            page_sel,
  output logic [7*DIGITS-1:0]   hex,
  output logic [1:0]            page,
  output logic                  stale
);

  localparam int unsigned HEX_W      = 7 * DIGITS;
  localparam int unsigned SEC_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BLINK_HALF = (CLK_HZ / (2 * BLINK_HZ) > 0) ? CLK_HZ / (2 * BLINK_HZ) : 1;
  localparam int unsigned BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned ROT_W      = $clog2(ROTATE_S + 1);
  localparam int unsigned STL_W      = $clog2(STALE_S + 1);

  localparam logic [SEC_W-1:0] SEC_LAST   = SEC_W'(CLK_HZ - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_HALF - 1);
  localparam logic [ROT_W-1:0] ROT_LAST   = ROT_W'(ROTATE_S - 1);
  localparam logic [STL_W-1:0] STL_MAX    = STL_W'(STALE_S);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [13:0] PAIR_BLANK = {SEG_BLANK, SEG_BLANK};

  typedef struct packed {
    logic [6:0] second;
    logic [6:0] minute;
    logic [5:0] hour;
    logic [5:0] day;
    logic [2:0] week_day;
    logic [4:0] month;
    logic [7:0] year;
  } fields_t;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  function automatic logic [13:0] bcd_pair(input logic [7:0] v);
    return {seg7(v[7:4]), seg7(v[3:0])};
  endfunction

  fields_t           hold_q, hold_d;
  logic [SEC_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic [STL_W-1:0]  stale_cnt_q, stale_cnt_d;
  logic              stale_q, stale_d;
  logic [ROT_W-1:0]  rot_cnt_q, rot_cnt_d;
  logic              auto_prev_q, auto_prev_d;
  logic [1:0]        page_q, page_d;
  logic [HEX_W-1:0]  hex_q, hex_d;
  logic              sec_tick;

  logic [13:0] sec_p, min_p, hour_p, day_p, mon_p, year_p, wday_p;
  logic [HEX_W-1:0] frame;

  always_comb begin
    hold_d = hold_q;
    if (load) hold_d = {second, minute, hour, day, week_day, month, year};

    sec_tick  = (sec_cnt_q == SEC_LAST);
    sec_cnt_d = sec_tick ? '0 : sec_cnt_q + 1'b1;

    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  // stale_q comes out of reset set while the count is 0, so it is held
  // sticky until the first load rather than recomputed from the count alone.
  always_comb begin
    stale_cnt_d = stale_cnt_q;
    if (load)
      stale_cnt_d = '0;
    else if (sec_tick && stale_cnt_q != STL_MAX)
      stale_cnt_d = stale_cnt_q + 1'b1;
    stale_d = !load && (stale_q || stale_cnt_d == STL_MAX);
  end

  always_comb begin
    auto_prev_d = auto_mode;
    rot_cnt_d   = rot_cnt_q;
    page_d      = page_q;
    if (!auto_mode) begin
      page_d    = page_sel;
      rot_cnt_d = '0;
    end else if (!auto_prev_q) begin
      rot_cnt_d = '0;
    end else if (sec_tick) begin
      if (rot_cnt_q == ROT_LAST) begin
        rot_cnt_d = '0;
        page_d    = page_q + 2'd1;
      end else begin
        rot_cnt_d = rot_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    sec_p  = bcd_pair({1'b0, hold_q.second});
    min_p  = bcd_pair({1'b0, hold_q.minute});
    hour_p = bcd_pair({2'b00, hold_q.hour});
    day_p  = bcd_pair({2'b00, hold_q.day});
    mon_p  = bcd_pair({3'b000, hold_q.month});
    year_p = bcd_pair(hold_q.year);
    wday_p = {SEG_BLANK, (hold_q.week_day == 3'd0) ? SEG_DASH : seg7({1'b0, hold_q.week_day})};
  end

  generate
    if (ROTATE_S < 1 || STALE_S < 1) begin : g_bad_period
      $error("dcf77_display: ROTATE_S and STALE_S must be at least 1");
    end
    if (DIGITS == 6) begin : g_six
      always_comb begin
        frame = '1;
        case (page_q)
          2'd0: frame = {hour_p, min_p, sec_p};
          2'd1: frame = {day_p, mon_p, year_p};
          2'd2: frame = {PAIR_BLANK, PAIR_BLANK, wday_p};
          2'd3: frame = {year_p, wday_p, sec_p};
          default: frame = '1;
        endcase
      end
    end else if (DIGITS == 4) begin : g_four
      always_comb begin
        frame = '1;
        case (page_q)
          2'd0: frame = {hour_p, min_p};
          2'd1: frame = {min_p, sec_p};
          2'd2: frame = {day_p, mon_p};
          2'd3: frame = {year_p, wday_p};
          default: frame = '1;
        endcase
      end
    end else begin : g_bad_digits
      $error("dcf77_display: DIGITS must be 4 or 6");
      always_comb frame = '1;
    end
  endgenerate

  always_comb begin
    hex_d = frame;
    if ((error || stale_q) && blink_ph_q) hex_d = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      sec_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      stale_cnt_q <= '0;
      stale_q     <= 1'b1;
      rot_cnt_q   <= '0;
      auto_prev_q <= 1'b0;
      page_q      <= 2'd0;
      hex_q       <= '1;
    end else begin
      hold_q      <= hold_d;
      sec_cnt_q   <= sec_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
      rot_cnt_q   <= rot_cnt_d;
      auto_prev_q <= auto_prev_d;
      page_q      <= page_d;
      hex_q       <= hex_d;
    end
  end

  assign hex   = hex_q;
  assign page  = page_q;
  assign stale = stale_q;

endmodule
